g11620_pix_accum: RTL and testbench

- Downstream stage of the G11620 sensor controller.
- Captures the ADC pixel stream that follows each sensor AD_SP pulse.
- Accumulates pixel-by-pixel over a configured number of scans into an internal line buffer.
- Streams the summed line out on a valid/ready interface, then pulses done.
- Sits between the ADC/sensor pins and the host readout FIFO/DMA.

---
 rtl/g11620_pix_accum_pkg.sv | 18 +
 rtl/g11620_pix_accum_if.sv | 14 +
 rtl/g11620_pix_accum_line_ram.sv | 28 ++
 rtl/g11620_pix_accum.sv | 179 +++++++++++++++++
 tb/tb_g11620_pix_accum.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/g11620_pix_accum_pkg.sv
// Shared definitions for the G11620 pixel accumulator: controller states and
// default geometry of the sensor line and ADC sample.
package g11620_pix_accum_pkg;

  localparam int PIX_NUM_DEF = 512;
  localparam int ADC_W_DEF   = 16;
  localparam int SCAN_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_SP = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_OUTPUT  = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/g11620_pix_accum_if.sv
// Valid/ready stream carrying accumulated pixel sums towards the host FIFO/DMA.
interface g11620_pix_accum_if #(
  parameter int ACC_W = 24
) ();

  logic             m_valid;
  logic             m_ready;
  logic [ACC_W-1:0] m_data;
  logic             m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/g11620_pix_accum_line_ram.sv
// Simple dual-port line buffer: synchronous write, registered read, no reset on
// the storage or read register so it maps onto block RAM.
module g11620_pix_accum_line_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 24,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/g11620_pix_accum.sv
// Multi-scan pixel accumulator: captures the ADC line after each AD_SP pulse,
// sums it into a line buffer over N scans, then streams the sums out.
module g11620_pix_accum
  import g11620_pix_accum_pkg::*;
#(
  parameter int PIX_NUM = PIX_NUM_DEF,
  parameter int ADC_W   = ADC_W_DEF,
  parameter int SCAN_W  = SCAN_W_DEF,
  parameter int ACC_W   = ADC_W + SCAN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_in,
  input  logic              soft_reset_in,
  input  logic [SCAN_W-1:0] scan_num_in,
  input  logic              ad_sp,
  input  logic [ADC_W-1:0]  adc_data,
  g11620_pix_accum_if.master m,
  output logic              busy_o,
  output logic              done_o
);

  localparam int PIX_W = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
  localparam logic [PIX_W-1:0] LAST_IDX = PIX_W'(PIX_NUM - 1);

  state_e            state_q, state_d;
  logic              start_r_q, start_r_d;
  logic [SCAN_W-1:0] scan_tot_q, scan_tot_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              drain_cnt_q, drain_cnt_d;
  logic              s1_valid_q, s1_valid_d;
  logic [ADC_W-1:0]  s1_sample_q, s1_sample_d;
  logic [PIX_W-1:0]  s1_idx_q, s1_idx_d;
  logic              m_valid_q, m_valid_d;
  logic [PIX_W-1:0]  beat_idx_q, beat_idx_d;

  logic              start_edge;
  logic              fire;
  logic [PIX_W-1:0]  rd_addr;
  logic [ACC_W-1:0]  rd_data;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W-1:0]  wr_data;

  assign start_edge = start_in & ~start_r_q;
  assign fire       = m_valid_q & m.m_ready;

  // Stage 2 of the read-modify-write: scan 0 ignores whatever the buffer holds.
  assign acc_base = (scan_cnt_q == '0) ? '0 : rd_data;
  assign wr_data  = ACC_W'(s1_sample_q) + acc_base;

  always_comb begin
    state_d     = state_q;
    start_r_d   = start_in;
    scan_tot_d  = scan_tot_q;
    scan_cnt_d  = scan_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    drain_cnt_d = drain_cnt_q;
    s1_valid_d  = 1'b0;
    s1_sample_d = s1_sample_q;
    s1_idx_d    = s1_idx_q;
    m_valid_d   = m_valid_q;
    beat_idx_d  = beat_idx_q;
    rd_addr     = pix_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          scan_tot_d = scan_num_in;
          scan_cnt_d = '0;
          state_d    = ST_WAIT_SP;
        end
      end
      ST_WAIT_SP: begin
        if (ad_sp) begin
          pix_cnt_d = '0;
          state_d   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        s1_valid_d  = 1'b1;
        s1_sample_d = adc_data;
        s1_idx_d    = pix_cnt_q;
        pix_cnt_d   = pix_cnt_q + 1'b1;
        if (pix_cnt_q == LAST_IDX) begin
          pix_cnt_d   = '0;
          drain_cnt_d = 1'b0;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = ~drain_cnt_q;
        if (drain_cnt_q) begin
          if (scan_cnt_q == scan_tot_q) begin
            beat_idx_d = '0;
            state_d    = ST_OUTPUT;
          end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
            state_d    = ST_WAIT_SP;
          end
        end
      end
      ST_OUTPUT: begin
        // Re-reading the current address while stalled keeps m_data stable.
        rd_addr = (fire && beat_idx_q != LAST_IDX) ? beat_idx_q + 1'b1 : beat_idx_q;
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
        end else if (fire) begin
          if (beat_idx_q == LAST_IDX) begin
            m_valid_d = 1'b0;
            state_d   = ST_DONE;
          end else begin
            beat_idx_d = beat_idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (soft_reset_in) begin
      state_d    = ST_IDLE;
      m_valid_d  = 1'b0;
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      start_r_q   <= 1'b0;
      scan_tot_q  <= '0;
      scan_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      drain_cnt_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sample_q <= '0;
      s1_idx_q    <= '0;
      m_valid_q   <= 1'b0;
      beat_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      start_r_q   <= start_r_d;
      scan_tot_q  <= scan_tot_d;
      scan_cnt_q  <= scan_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_sample_q <= s1_sample_d;
      s1_idx_q    <= s1_idx_d;
      m_valid_q   <= m_valid_d;
      beat_idx_q  <= beat_idx_d;
    end
  end

  g11620_pix_accum_line_ram #(
    .DEPTH (PIX_NUM),
    .WIDTH (ACC_W),
    .AW    (PIX_W)
  ) u_line_ram (
    .clk     (clk),
    .we      (s1_valid_q),
    .wr_addr (s1_idx_q),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign m.m_valid = m_valid_q;
  assign m.m_data  = m_valid_q ? rd_data : '0;
  assign m.m_last  = m_valid_q && (beat_idx_q == LAST_IDX);
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);

endmodule

// File: tb/tb_g11620_pix_accum.sv
// Directed bench for the pixel accumulator; a 64-pixel line keeps the 256-scan
// overflow run short while exercising the same control paths.
module tb_g11620_pix_accum;
  import g11620_pix_accum_pkg::*;

  localparam int PIX    = 64;
  localparam int ADC_W  = 16;
  localparam int SCAN_W = 8;
  localparam int ACC_W  = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_in = 1'b0;
  logic              soft_reset_in = 1'b0;
  logic [SCAN_W-1:0] scan_num_in = '0;
  logic              ad_sp = 1'b0;
  logic [ADC_W-1:0]  adc_data = '0;
  logic              busy_o;
  logic              done_o;

  int passed = 0;
  int total  = 0;
  logic [ACC_W-1:0] exp_mem [PIX];

  g11620_pix_accum_if #(.ACC_W(ACC_W)) bus ();

  g11620_pix_accum #(
    .PIX_NUM (PIX),
    .ADC_W   (ADC_W),
    .SCAN_W  (SCAN_W),
    .ACC_W   (ACC_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_in      (start_in),
    .soft_reset_in (soft_reset_in),
    .scan_num_in   (scan_num_in),
    .ad_sp         (ad_sp),
    .adc_data      (adc_data),
    .m             (bus),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  // A sensor pulse landing in DRAIN would be dropped by the design.
  always @(posedge clk) begin
    if (rst_n && ad_sp && dut.state_q == ST_DRAIN)
      $error("ad_sp arrived while draining");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [SCAN_W-1:0] n);
    scan_num_in = n;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    scan_num_in = '0;
  endtask

  task automatic feed_scan(input logic [ADC_W-1:0] base, input bit ramp, input bit spur);
    ad_sp = 1'b1;
    tick();
    ad_sp = 1'b0;
    for (int i = 0; i < PIX; i++) begin
      adc_data = ramp ? base + ADC_W'(i) : base;
      ad_sp = spur && (i == 10 || i == 40);
      tick();
    end
    ad_sp = 1'b0;
    adc_data = '0;
    repeat (4) tick();
  endtask

  task automatic run_output(input bit rand_ready, input bit spur_start, input string tag);
    int beats = 0;
    bit stalled = 0;
    bit seen_done = 0;
    bit rdy;
    logic [ACC_W-1:0] hd = '0;
    logic hl = 1'b0;
    logic exp_last;
    for (int cyc = 0; cyc < PIX * 6 + 100 && !seen_done; cyc++) begin
      if (bus.m_valid && stalled) begin
        total++;
        if (bus.m_data !== hd || bus.m_last !== hl)
          $display("FAIL %s hold: data %h last %b, required %h last %b", tag, bus.m_data, bus.m_last, hd, hl);
        else
          passed++;
      end
      if (spur_start) start_in = (cyc == 20);
      rdy = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.m_ready = rdy;
      if (bus.m_valid) begin
        if (rdy) begin
          if (beats < PIX) begin
            exp_last = (beats == PIX - 1);
            total++;
            if (bus.m_data !== exp_mem[beats] || bus.m_last !== exp_last)
              $display("FAIL %s beat %0d: data %h last %b, required %h last %b",
                       tag, beats, bus.m_data, bus.m_last, exp_mem[beats], exp_last);
            else
              passed++;
          end
          beats++;
          stalled = 0;
        end else begin
          stalled = 1;
          hd = bus.m_data;
          hl = bus.m_last;
        end
      end
      tick();
      if (done_o) seen_done = 1;
    end
    bus.m_ready = 1'b0;
    start_in = 1'b0;
    total++;
    if (!seen_done) $display("FAIL %s done: no done_o pulse within budget", tag);
    else passed++;
    total++;
    if (beats != PIX) $display("FAIL %s beat count: got %0d, required %0d", tag, beats, PIX);
    else passed++;
    tick();
    total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || bus.m_valid !== 1'b0)
      $display("FAIL %s after done: done %b busy %b valid %b, required 0 0 0", tag, done_o, busy_o, bus.m_valid);
    else
      passed++;
    $display("%s: %0d beats transferred", tag, beats);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) tick();
    total++; if (bus.m_valid !== 1'b0) $display("FAIL reset m_valid: got %b, required 0", bus.m_valid); else passed++;
    total++; if (bus.m_data !== '0) $display("FAIL reset m_data: got %h, required 0", bus.m_data); else passed++;
    total++; if (bus.m_last !== 1'b0) $display("FAIL reset m_last: got %b, required 0", bus.m_last); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL reset busy_o: got %b, required 0", busy_o); else passed++;
    total++; if (done_o !== 1'b0) $display("FAIL reset done_o: got %b, required 0", done_o); else passed++;
    rst_n = 1'b1;
    tick();
    ad_sp = 1'b1;
    tick();
    ad_sp = 1'b0;
    total++; if (busy_o !== 1'b0) $display("FAIL idle ad_sp: busy_o %b, required 0", busy_o); else passed++;
    $display("reset: outputs checked");
  endtask

  task automatic test_single_scan();
    for (int i = 0; i < PIX; i++) exp_mem[i] = ACC_W'(i);
    arm(8'd0);
    feed_scan(16'h0000, 1'b1, 1'b0);
    run_output(1'b0, 1'b0, "single");
  endtask

  task automatic test_accum();
    for (int i = 0; i < PIX; i++) exp_mem[i] = 4 * (24'h001000 + ACC_W'(i));
    arm(8'd3);
    repeat (4) feed_scan(16'h1000, 1'b1, 1'b0);
    run_output(1'b0, 1'b0, "accum");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < PIX; i++) exp_mem[i] = 24'hFFFF00;
    arm(8'd255);
    repeat (256) feed_scan(16'hFFFF, 1'b0, 1'b0);
    run_output(1'b0, 1'b0, "overflow");
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < PIX; i++) exp_mem[i] = 24'h000300 + ACC_W'(i);
    arm(8'd0);
    feed_scan(16'h0300, 1'b1, 1'b0);
    run_output(1'b1, 1'b0, "backpressure");
  endtask

  task automatic test_soft_reset();
    bit bad = 0;
    arm(8'd3);
    repeat (2) feed_scan(16'h0777, 1'b1, 1'b0);
    ad_sp = 1'b1;
    tick();
    ad_sp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      adc_data = 16'h0777 + 16'(i);
      tick();
    end
    soft_reset_in = 1'b1;
    tick();
    soft_reset_in = 1'b0;
    total++; if (busy_o !== 1'b0) $display("FAIL softreset busy_o: got %b, required 0", busy_o); else passed++;
    total++; if (bus.m_valid !== 1'b0) $display("FAIL softreset m_valid: got %b, required 0", bus.m_valid); else passed++;
    bus.m_ready = 1'b1;
    for (int i = 0; i < PIX + 40; i++) begin
      adc_data = 16'h0777 + 16'(i);
      ad_sp = (i == PIX);
      tick();
      if (bus.m_valid || done_o || busy_o) bad = 1;
    end
    ad_sp = 1'b0;
    bus.m_ready = 1'b0;
    total++; if (bad) $display("FAIL softreset quiet: activity seen after abort, required none"); else passed++;
    soft_reset_in = 1'b1;
    start_in = 1'b1;
    tick();
    soft_reset_in = 1'b0;
    start_in = 1'b0;
    total++; if (busy_o !== 1'b0) $display("FAIL softreset+start busy_o: got %b, required 0", busy_o); else passed++;
    tick();
    for (int i = 0; i < PIX; i++) exp_mem[i] = 24'h000200 + ACC_W'(i);
    arm(8'd0);
    feed_scan(16'h0200, 1'b1, 1'b0);
    run_output(1'b0, 1'b0, "after_softreset");
  endtask

  task automatic test_spurious();
    for (int i = 0; i < PIX; i++) exp_mem[i] = 2 * (24'h000500 + ACC_W'(i));
    arm(8'd1);
    repeat (2) feed_scan(16'h0500, 1'b1, 1'b1);
    run_output(1'b0, 1'b1, "spurious");
  endtask

  initial begin
    bus.m_ready = 1'b0;
    test_reset();
    test_single_scan();
    test_accum();
    test_overflow();
    test_backpressure();
    test_soft_reset();
    test_spurious();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
